// File: rtl/wide_add_sequencer_if.sv
// Request/response bus of the wide add/subtract sequencer.
// The master side is the operand source / result sink; the slave side is the sequencer.
interface wide_add_sequencer_if #(
  parameter int NWORDS = 4
);
  localparam int W = NWORDS * 64;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Wide (NWORDS*64-bit) add/subtract built by time-multiplexing one external
// combinational 64-bit adder, least-significant word first, with the carry
// chained through a register. Subtract is A + ~B + 1: B words are inverted on
// the way to the adder and the initial carry is seeded with 1.
module wide_add_sequencer #(
  parameter int NWORDS = 4,
  parameter int IDXW   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  wide_add_sequencer_if.slave        bus,
  output logic [63:0]                adder_a,
  output logic [63:0]                adder_b,
  output logic                       adder_cin,
  input  logic [63:0]                adder_sum,
  input  logic                       adder_cout
);
  localparam int              W        = NWORDS * 64;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [63:0]     word_a;
  logic [63:0]     word_b;
  logic            last_word;

  assign last_word = (idx_q == LAST_IDX);

  // Handshake and result outputs; the result comes straight from registers.
  assign bus.in_ready  = (state_q == S_IDLE) && !rst;
  assign bus.out_valid = (state_q == S_DONE) && !rst;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;

  // Pick the operand words addressed by idx; B is inverted for subtract.
  always_comb begin
    word_a = 64'd0;
    word_b = 64'd0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx_q == IDXW'(i)) begin
        word_a = a_q[i*64 +: 64];
        word_b = b_q[i*64 +: 64] ^ {64{sub_q}};
      end else begin
        word_a = word_a;
        word_b = word_b;
      end
    end
  end

  // Feed the external adder only while sequencing; park it at zero otherwise.
  always_comb begin
    if (state_q == S_BUSY) begin
      adder_a   = word_a;
      adder_b   = word_b;
      adder_cin = carry_q;
    end else begin
      adder_a   = 64'd0;
      adder_b   = 64'd0;
      adder_cin = 1'b0;
    end
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          sub_d   = bus.in_sub;
          idx_d   = {IDXW{1'b0}};
          carry_d = bus.in_sub;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        for (int i = 0; i < NWORDS; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[i*64 +: 64] = adder_sum;
          end else begin
            sum_d[i*64 +: 64] = sum_q[i*64 +: 64];
          end
        end
        carry_d = adder_cout;
        if (last_word) begin
          // Sign overflow: same-sign adder inputs producing a different-sign sum.
          cout_d  = adder_cout;
          ovf_d   = (adder_a[63] == adder_b[63]) && (adder_sum[63] != adder_a[63]);
          idx_d   = {IDXW{1'b0}};
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
          state_d = S_BUSY;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sub_q   <= 1'b0;
      idx_q   <= {IDXW{1'b0}};
      carry_q <= 1'b0;
      sum_q   <= {W{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: a W-bit arithmetic reference
// model plus directed literal cases, with randomized back-to-back traffic.
module tb_wide_add_sequencer;
  localparam int NWORDS = 4;
  localparam int IDXW   = 4;
  localparam int W      = NWORDS * 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout;

  wide_add_sequencer_if #(.NWORDS(NWORDS)) bus ();

  wide_add_sequencer #(.NWORDS(NWORDS), .IDXW(IDXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout)
  );

  always #5 clk = ~clk;

  // The external 64-bit adder.
  always_comb {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {64'd0, adder_cin};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_done   = 0;
  int n_abort  = 0;

  // Reference model: at most one operation outstanding.
  logic         m_pending = 1'b0;
  int           m_acc_cyc = 0;
  logic [W-1:0] m_a, m_b, m_sum;
  logic         m_sub, m_cout, m_ovf;
  int           age, j;
  logic         exp_ready, exp_valid;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0:       v = {W{1'b1}};
      1:       v = {W{1'b0}};
      2:       v = v & W'(255);
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = v;
    endcase
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    logic [W-1:0] bx;
    logic [W:0]   full;
    age       = cyc - m_acc_cyc;
    exp_ready = !m_pending && !rst;
    exp_valid = m_pending && !rst && (age >= NWORDS + 1);
    chk("in_ready", W'(bus.in_ready), W'(exp_ready));
    chk("out_valid", W'(bus.out_valid), W'(exp_valid));
    if (exp_valid) begin
      chk("model_sum", bus.out_sum, m_sum);
      chk("model_cout", W'(bus.out_cout), W'(m_cout));
      chk("model_ovf", W'(bus.out_ovf), W'(m_ovf));
    end
    if (m_pending && !rst && age >= 1 && age <= NWORDS) begin
      j = age - 1;
      chk("adder_a_word", W'(adder_a), W'(m_a[j*64 +: 64]));
      chk("adder_b_word", W'(adder_b), W'(m_b[j*64 +: 64] ^ {64{m_sub}}));
      if (j == 0) chk("adder_cin_first", W'(adder_cin), W'(m_sub));
    end else begin
      chk("adder_parked", W'({adder_cin, adder_a | adder_b}), W'(0));
    end

    if (rst) begin
      if (m_pending) n_abort++;
      m_pending = 1'b0;
    end else if (exp_valid && bus.out_ready) begin
      m_pending = 1'b0;
      n_done++;
    end else if (exp_ready && bus.in_valid) begin
      m_pending = 1'b1;
      m_acc_cyc = cyc;
      m_a       = bus.in_a;
      m_b       = bus.in_b;
      m_sub     = bus.in_sub;
      bx        = m_sub ? ~m_b : m_b;
      full      = {1'b0, m_a} + {1'b0, bx} + (W+1)'(m_sub);
      m_sum     = full[W-1:0];
      m_cout    = full[W];
      m_ovf     = (m_a[W-1] == bx[W-1]) && (m_sum[W-1] != m_a[W-1]);
      n_acc++;
    end
  end

  // One directed operation with literal expectations; with rdy=0 it returns
  // at the first negedge that shows out_valid, leaving the result held.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf, input logic rdy);
    bit got;
    @(posedge clk); #1;
    bus.in_a = a; bus.in_b = b; bus.in_sub = s; bus.in_valid = 1'b1; bus.out_ready = rdy;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    chk({name, "_accept"}, W'(got), W'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = rand_w(); bus.in_b = rand_w(); bus.in_sub = ~s;
    if (!got) return;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    chk({name, "_done"}, W'(got), W'(1));
    if (!got) return;
    chk({name, "_sum"}, bus.out_sum, e_sum);
    chk({name, "_cout"}, W'(bus.out_cout), W'(e_cout));
    chk({name, "_ovf"}, W'(bus.out_ovf), W'(e_ovf));
    if (rdy) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit drained;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = {W{1'b0}}; bus.in_b = {W{1'b0}};
    bus.in_sub = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_sum", bus.out_sum, W'(0));
    chk("reset_cout_ovf", W'({bus.out_cout, bus.out_ovf}), W'(0));
    chk("reset_valid", W'(bus.out_valid), W'(0));

    run_op("add_ripple", {W{1'b1}}, W'(1), 1'b0, W'(0), 1'b1, 1'b0, 1'b1);
    run_op("add_ovf", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1, 1'b1);
    run_op("sub_borrow", W'(5), W'(7), 1'b1, {{(W-4){1'b1}}, 4'hE}, 1'b0, 1'b0, 1'b1);
    run_op("sub_equal", W'(16'h1234), W'(16'h1234), 1'b1, W'(0), 1'b1, 1'b0, 1'b1);

    // Backpressure: result must hold while the source wiggles.
    run_op("bp", W'(10), W'(20), 1'b0, W'(30), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.in_a = rand_w(); bus.in_b = rand_w(); bus.in_valid = k[0];
      @(negedge clk);
      chk("bp_hold_sum", bus.out_sum, W'(30));
      chk("bp_in_ready", W'(bus.in_ready), W'(0));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_after_handoff", W'(bus.in_ready), W'(1));

    // Abort: reset lands while the third word is in the adder.
    @(posedge clk); #1;
    bus.in_a = W'(100); bus.in_b = W'(200); bus.in_sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", W'(bus.in_ready), W'(1));
    chk("abort_no_valid", W'(bus.out_valid), W'(0));
    run_op("after_abort", W'(3), W'(4), 1'b0, W'(7), 1'b0, 1'b0, 1'b1);

    // Randomized back-to-back traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_a      = rand_w();
      bus.in_b      = rand_w();
      bus.in_sub    = $urandom_range(0, 1) == 1;
      bus.out_ready = $urandom_range(0, 1) == 1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drained = 1'b0;
    for (int n = 0; n < 50 && !drained; n++) begin
      @(negedge clk);
      if (!m_pending) drained = 1'b1;
    end
    chk("drain", W'(drained), W'(1));
    chk("no_drop_dup", W'(n_acc), W'(n_done + n_abort));
    chk("abort_count", W'(n_abort), W'(1));
    chk("traffic_seen", W'(n_done > 100), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs NWORDS*64-bit add/subtract by time-multiplexing one external 64-bit carry-lookahead adder, least-significant word first, with carry chained through a register.
- Sits between a valid/ready operand source and a valid/ready result sink; the 64-bit adder is instantiated alongside and connected through the adder_* ports.
- The adder is purely combinational; this block owns all sequencing, operand inversion for subtract, and result assembly.

Parameters:
- NWORDS, 4, number of 64-bit words per operand (operand width W = NWORDS*64); legal range 2..16.
- IDXW, 4, width of the word index counter; must satisfy 2**IDXW >= NWORDS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_sub  input  1  1 = compute A-B, 0 = compute A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- out_sum  output  W  result, modulo 2**W.
- out_cout  output  1  final carry out (for subtract, 1 = no borrow, A >= B unsigned).
- out_ovf  output  1  signed two's-complement overflow.
- adder_a  output  64  word to adder input A.
- adder_b  output  64  word to adder input B (already inverted for subtract).
- adder_cin  output  1  adder carry in.
- adder_sum  input  64  adder sum.
- adder_cout  input  1  adder carry out.

Behaviour:
- States: IDLE, BUSY, DONE. Registers: a_reg, b_reg, sub_reg, idx, carry_reg, sum_reg, cout_reg, ovf_reg.
- Reset (rst=1 at an edge): state=IDLE, idx=0, carry_reg=0, sum_reg=0, cout_reg=0, ovf_reg=0. While rst=1: in_ready=0, out_valid=0. Reset mid-BUSY or in DONE aborts the operation; no result is presented.
- in_ready = (state==IDLE) && !rst. out_valid = (state==DONE). out_sum, out_cout and out_ovf are driven from registers and are stable for the whole DONE interval.
- IDLE: on in_valid && in_ready, latch in_a, in_b and in_sub; set idx=0 and carry_reg=in_sub; go to BUSY. Otherwise stay in IDLE.
- BUSY, combinational outputs:
  - adder_a = a_reg word idx.
  - adder_b = b_reg word idx XOR {64{sub_reg}}.
  - adder_cin = carry_reg.
- BUSY, at each edge:
  - sum_reg word idx <= adder_sum; carry_reg <= adder_cout; idx <= idx+1.
  - When idx==NWORDS-1: also capture cout_reg <= adder_cout and ovf_reg <= (adder_a[63] == adder_b[63]) && (adder_sum[63] != adder_a[63]); go to DONE.
- In IDLE and DONE, adder_a=0, adder_b=0, adder_cin=0.
- DONE: hold the result. On out_ready, go to IDLE at that edge, with out_valid deasserting in the next cycle. No new request is accepted in the same cycle as the handoff.
- Latency: request accepted at edge E, out_valid high starting the cycle after edge E+NWORDS. Minimum spacing between accepts is NWORDS+2 cycles with out_ready tied high.
- The operand source may change in_a, in_b or in_sub after the accept edge without affecting the result.
- idx never exceeds NWORDS-1. No other wrap-around is possible.
- Sum and carry semantics match a single W-bit adder: sum = (A + (sub ? ~B : B) + sub) mod 2**W.

Test Plan:
- NWORDS=4, add A=2**256-1, B=1 -> out_sum=0, out_cout=1, out_ovf=0; out_valid rises exactly 4 cycles after the accept edge; carry ripples through all 4 words.
- Add A=0x7FFF...F (256-bit max positive), B=1 -> out_sum=0x8000...0, out_cout=0, out_ovf=1.
- Subtract A=5, B=7 -> out_sum=2**256-2 (all F except LSB nibble E), out_cout=0 (borrow), out_ovf=0. Subtract A=B=0x1234 -> out_sum=0, out_cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_a, in_b and in_valid -> out_sum stable, in_ready=0 throughout; release -> in_ready=1 the cycle after the handoff.
- Reset asserted for one cycle while in BUSY with idx=2 -> next cycle state IDLE, out_valid never asserts for the aborted op; a following add 3+4 returns 7.
- Randomized back-to-back requests with out_ready randomly toggled, compared against a W-bit reference model -> all results match; no request dropped or duplicated.
